// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core: oversampled UART receiver.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
// one stop bit (1). rx_in is sampled once per bit at edge_cnt = prescale/2.
// Build option: define UART_RX_MAJORITY_EN to use a 2-of-3 majority of the
// samples at prescale/2-1, prescale/2 and prescale/2+1 instead.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]      ZERO_B   = BIT_W'(0);
  localparam logic [BIT_W-1:0]      ONE_B    = BIT_W'(1);
  localparam logic [PRESCALE_W-1:0] ZERO_P   = PRESCALE_W'(0);
  localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO_D   = DATA_WIDTH'(0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [PRESCALE_W-1:0] presc_r;
  logic [PRESCALE_W-1:0] edge_cnt_r;
  logic [PRESCALE_W-1:0] mid_s;
  logic [PRESCALE_W-1:0] last_s;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  armed_r;
  logic                  par_bad_r;
  logic                  stop_bad_r;
  logic                  done_r;
  logic                  bit_s;
  logic                  last_edge_s;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stop_err_r;
  logic                  busy_r;
  logic                  dv_nx_s;
  logic                  pe_nx_s;
  logic                  se_nx_s;

  // Expected parity bit: even parity of the data, inverted for odd parity
  function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Bit timing is taken from the prescale value latched at frame start
  assign mid_s       = presc_r >> 3'd1;
  assign last_s      = presc_r - ONE_P;
  assign last_edge_s = (edge_cnt_r == last_s);

`ifdef UART_RX_MAJORITY_EN
  logic samp_lo_r;
  logic samp_mid_r;
  logic samp_hi_r;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture three line samples centred on mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_lo_r  <= 1'b1;
      samp_mid_r <= 1'b1;
      samp_hi_r  <= 1'b1;
    end else if (state_r != ST_IDLE) begin
      if (edge_cnt_r == (mid_s - ONE_P)) samp_lo_r  <= rx_in;
      if (edge_cnt_r == mid_s)           samp_mid_r <= rx_in;
      if (edge_cnt_r == (mid_s + ONE_P)) samp_hi_r  <= rx_in;
    end
  end

  assign bit_s = maj3(samp_lo_r, samp_mid_r, samp_hi_r);
`else
  logic samp_r;

  // Capture one line sample at mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_r <= 1'b1;
    end else if ((state_r != ST_IDLE) && (edge_cnt_r == mid_s)) begin
      samp_r <= rx_in;
    end
  end

  assign bit_s = samp_r;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; every non-idle state advances on the last edge of its bit
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (armed_r && !rx_in) state_nx_s = ST_START;
        else                   state_nx_s = ST_IDLE;
      end
      ST_START: begin
        if (last_edge_s) state_nx_s = bit_s ? ST_IDLE : ST_DATA;
        else             state_nx_s = ST_START;
      end
      ST_DATA: begin
        if (last_edge_s && (bit_cnt_r == LAST_BIT)) state_nx_s = par_en ? ST_PARITY : ST_STOP;
        else                                        state_nx_s = ST_DATA;
      end
      ST_PARITY: begin
        if (last_edge_s) state_nx_s = ST_STOP;
        else             state_nx_s = ST_PARITY;
      end
      ST_STOP: begin
        if (last_edge_s) state_nx_s = ST_IDLE;
        else             state_nx_s = ST_STOP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Counters, shift register, frame status and arming of the start detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r    <= ZERO_P;
      edge_cnt_r <= ZERO_P;
      bit_cnt_r  <= ZERO_B;
      shift_r    <= ZERO_D;
      armed_r    <= 1'b1;
      par_bad_r  <= 1'b0;
      stop_bad_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      edge_cnt_r <= ((state_r == ST_IDLE) || last_edge_s) ? ZERO_P : (edge_cnt_r + ONE_P);
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_in) armed_r <= 1'b1;
          if (state_nx_s == ST_START) presc_r <= prescale;
        end
        ST_START: begin
          bit_cnt_r <= ZERO_B;
          par_bad_r <= 1'b0;
        end
        ST_DATA: begin
          if (last_edge_s) begin
            shift_r[bit_cnt_r] <= bit_s;
            bit_cnt_r          <= (bit_cnt_r == LAST_BIT) ? ZERO_B : (bit_cnt_r + ONE_B);
          end
        end
        ST_PARITY: begin
          if (last_edge_s) par_bad_r <= (bit_s != exp_parity(shift_r, par_typ));
        end
        ST_STOP: begin
          if (last_edge_s) begin
            stop_bad_r <= !bit_s;
            done_r     <= 1'b1;
            // a low stop bit disarms so a held-low break reports only once
            armed_r    <= bit_s;
          end
        end
        default: begin
          bit_cnt_r <= ZERO_B;
        end
      endcase
    end
  end

  // End-of-frame result: stop error outranks parity error, one flag per frame
  always_comb begin
    dv_nx_s = 1'b0;
    pe_nx_s = 1'b0;
    se_nx_s = 1'b0;
    if (done_r) begin
      if (stop_bad_r) begin
        se_nx_s = 1'b1;
      end else if (par_bad_r) begin
        pe_nx_s = 1'b1;
      end else begin
        dv_nx_s = 1'b1;
      end
    end else begin
      dv_nx_s = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_data_r     <= ZERO_D;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stop_err_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      data_valid_r <= dv_nx_s;
      par_err_r    <= pe_nx_s;
      stop_err_r   <= se_nx_s;
      busy_r       <= (state_nx_s != ST_IDLE);
      if (dv_nx_s) p_data_r <= shift_r;
    end
  end

  assign p_data     = p_data_r;
  assign data_valid = data_valid_r;
  assign par_err    = par_err_r;
  assign stop_err   = stop_err_r;
  assign busy       = busy_r;

endmodule
